// File: rtl/sound_square_v2_if.sv
// Control and sample bus of the square-wave channel.
// master: register file / sequencer side; slave: the channel itself.
interface sound_square_v2_if #(
  parameter int DIV_W = 11,
  parameter int LEN_W = 6,
  parameter int VOL_W = 4
);
  logic             freq_tick_en;
  logic             len_tick_en;
  logic             env_tick_en;
  logic             sweep_tick_en;
  logic             trigger;
  logic             length_load;
  logic [LEN_W-1:0] length;
  logic             length_en;
  logic [1:0]       wave_duty;
  logic [DIV_W-1:0] frequency;
  logic [2:0]       sweep_period;
  logic             sweep_decreasing;
  logic [2:0]       sweep_shift;
  logic [VOL_W-1:0] initial_volume;
  logic             env_increasing;
  logic [2:0]       env_period;
  logic [VOL_W-1:0] level;
  logic             enable;
  logic [DIV_W-1:0] freq_cur;

  modport master (
    output freq_tick_en, len_tick_en, env_tick_en, sweep_tick_en, trigger,
           length_load, length, length_en, wave_duty, frequency, sweep_period,
           sweep_decreasing, sweep_shift, initial_volume, env_increasing, env_period,
    input  level, enable, freq_cur
  );

  modport slave (
    input  freq_tick_en, len_tick_en, env_tick_en, sweep_tick_en, trigger,
           length_load, length, length_en, wave_duty, frequency, sweep_period,
           sweep_decreasing, sweep_shift, initial_volume, env_increasing, env_period,
    output level, enable, freq_cur
  );
endinterface

// File: rtl/sound_square_v2.sv
// Square-wave channel (CH1/CH2 class) clocked only by the CPU clock.
// Frame-sequencer strobes drive the period timer, length counter, envelope
// and the optional frequency sweep with shadow register and overflow kill.
module sound_square_v2 #(
  parameter int DIV_W     = 11,
  parameter int LEN_W     = 6,
  parameter int VOL_W     = 4,
  parameter bit HAS_SWEEP = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  sound_square_v2_if.slave  bus
);

  localparam logic [DIV_W-1:0] FREQ_MAX  = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0] DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W:0]   LEN_FULL  = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]   LEN_ONE   = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [VOL_W-1:0] VOL_MAX   = {VOL_W{1'b1}};
  localparam logic [VOL_W-1:0] VOL_ONE   = {{(VOL_W-1){1'b0}}, 1'b1};

  // Waveform bit for the given duty setting at step position pos (1 = high).
  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] pos);
    logic [7:0] pat;
    case (duty)
      2'b00:   pat = 8'b0000_0001;
      2'b01:   pat = 8'b1000_0001;
      2'b10:   pat = 8'b1000_0111;
      2'b11:   pat = 8'b0111_1110;
      default: pat = 8'b0000_0000;
    endcase
    return pat[pos];
  endfunction

  // Next sweep frequency, one bit wider than the register so overflow is visible.
  function automatic logic [DIV_W:0] sweep_new(input logic [DIV_W-1:0] base,
                                               input logic dec, input logic [2:0] n);
    logic [DIV_W:0] wide;
    logic [DIV_W:0] delta;
    wide  = {1'b0, base};
    delta = wide >> n;
    if (dec) begin
      return wide - delta;
    end else begin
      return wide + delta;
    end
  endfunction

  logic [DIV_W-1:0] timer_r;
  logic [2:0]       duty_pos_r;
  logic [VOL_W-1:0] vol_r;
  logic [2:0]       env_timer_r;
  logic [LEN_W:0]   len_cnt_r;
  logic             enable_r;
  logic [DIV_W-1:0] shadow_r;
  logic [DIV_W-1:0] freq_cur_r;
  logic [3:0]       sweep_timer_r;
  logic             sweep_on_r;
  logic [VOL_W-1:0] level_r;

  logic             dac_on_s;
  logic [DIV_W-1:0] reload_freq_s;
  logic [LEN_W:0]   len_load_val_s;
  logic [3:0]       sweep_reload_s;
  logic             trig_ovf_s;
  logic [DIV_W:0]   tick_calc_s;
  logic             tick_ovf_s;
  logic             tick_check_ovf_s;

  // Decode of DAC power, reload values and both sweep overflow checks.
  always_comb begin
    dac_on_s         = (bus.initial_volume != {VOL_W{1'b0}}) | bus.env_increasing;
    reload_freq_s    = HAS_SWEEP ? freq_cur_r : bus.frequency;
    len_load_val_s   = LEN_FULL - {1'b0, bus.length};
    sweep_reload_s   = (bus.sweep_period != 3'd0) ? {1'b0, bus.sweep_period} : 4'd8;
    trig_ovf_s       = (sweep_new(bus.frequency, bus.sweep_decreasing, bus.sweep_shift)
                        > {1'b0, FREQ_MAX});
    tick_calc_s      = sweep_new(shadow_r, bus.sweep_decreasing, bus.sweep_shift);
    tick_ovf_s       = tick_calc_s[DIV_W];
    tick_check_ovf_s = (sweep_new(tick_calc_s[DIV_W-1:0], bus.sweep_decreasing, bus.sweep_shift)
                        > {1'b0, FREQ_MAX});
  end

  // Channel state: trigger restart, period timer, length, envelope and sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r       <= {DIV_W{1'b0}};
      duty_pos_r    <= 3'd0;
      vol_r         <= {VOL_W{1'b0}};
      env_timer_r   <= 3'd0;
      len_cnt_r     <= {(LEN_W+1){1'b0}};
      enable_r      <= 1'b0;
      shadow_r      <= {DIV_W{1'b0}};
      freq_cur_r    <= {DIV_W{1'b0}};
      sweep_timer_r <= 4'd0;
      sweep_on_r    <= 1'b0;
    end else begin
      if (bus.trigger) begin
        // Restart; all strobes in this cycle are dropped.
        enable_r    <= dac_on_s;
        timer_r     <= ~bus.frequency;
        vol_r       <= bus.initial_volume;
        env_timer_r <= bus.env_period;
        if (bus.length_load) begin
          len_cnt_r <= len_load_val_s;
        end else if (len_cnt_r == {(LEN_W+1){1'b0}}) begin
          len_cnt_r <= LEN_FULL;
        end
        if (HAS_SWEEP) begin
          shadow_r      <= bus.frequency;
          freq_cur_r    <= bus.frequency;
          sweep_timer_r <= sweep_reload_s;
          sweep_on_r    <= (bus.sweep_period != 3'd0) | (bus.sweep_shift != 3'd0);
          if ((bus.sweep_shift != 3'd0) && trig_ovf_s) begin
            enable_r <= 1'b0;
          end
        end
      end else begin
        // Period timer: a new frequency only lands at the next reload.
        if (bus.freq_tick_en) begin
          if (timer_r == {DIV_W{1'b0}}) begin
            timer_r    <= ~reload_freq_s;
            duty_pos_r <= duty_pos_r + 3'd1;
          end else begin
            timer_r <= timer_r - DIV_ONE;
          end
        end
        // Length counter: an explicit load beats the length strobe.
        if (bus.length_load) begin
          len_cnt_r <= len_load_val_s;
        end else if (bus.len_tick_en && bus.length_en && (len_cnt_r != {(LEN_W+1){1'b0}})) begin
          len_cnt_r <= len_cnt_r - LEN_ONE;
          if (len_cnt_r == LEN_ONE) begin
            enable_r <= 1'b0;
          end
        end
        // Envelope: saturating volume step each time its timer expires.
        if (bus.env_tick_en && (bus.env_period != 3'd0)) begin
          if (env_timer_r <= 3'd1) begin
            env_timer_r <= bus.env_period;
            if (bus.env_increasing) begin
              if (vol_r != VOL_MAX) begin
                vol_r <= vol_r + VOL_ONE;
              end
            end else if (vol_r != {VOL_W{1'b0}}) begin
              vol_r <= vol_r - VOL_ONE;
            end
          end else begin
            env_timer_r <= env_timer_r - 3'd1;
          end
        end
        // Sweep: recompute from the shadow, write back, then re-check ahead.
        if (HAS_SWEEP && bus.sweep_tick_en && enable_r) begin
          if (sweep_timer_r <= 4'd1) begin
            sweep_timer_r <= sweep_reload_s;
            if (sweep_on_r && (bus.sweep_period != 3'd0)) begin
              if (tick_ovf_s) begin
                enable_r <= 1'b0;
              end else if (bus.sweep_shift != 3'd0) begin
                shadow_r   <= tick_calc_s[DIV_W-1:0];
                freq_cur_r <= tick_calc_s[DIV_W-1:0];
                if (tick_check_ovf_s) begin
                  enable_r <= 1'b0;
                end
              end
            end
          end else begin
            sweep_timer_r <= sweep_timer_r - 4'd1;
          end
        end
      end
      // Without a sweep unit the readback simply mirrors the register.
      if (!HAS_SWEEP) begin
        freq_cur_r <= bus.frequency;
      end
      // A powered-down DAC holds the channel off regardless of anything above.
      if (!dac_on_s) begin
        enable_r <= 1'b0;
      end
    end
  end

  // Output sample, one clock behind duty position, volume and enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= {VOL_W{1'b0}};
    end else if (enable_r && duty_bit(bus.wave_duty, duty_pos_r)) begin
      level_r <= vol_r;
    end else begin
      level_r <= {VOL_W{1'b0}};
    end
  end

  assign bus.level    = level_r;
  assign bus.enable   = enable_r;
  assign bus.freq_cur = freq_cur_r;

endmodule
